// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg: shared types and default widths
// for the VGA / CPU display memory arbiter.
package vga_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    VGA    = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } own_t;

endpackage

// File: rtl/vga_mem_arbiter_wait_counter.sv
// arb_wait_counter: saturating refusal counter with clear,
// flags when the CPU has waited MAX refused cycles.
module arb_wait_counter #(
  parameter int MAX = 8
) (
  input  logic clkIn,
  input  logic rstN,
  input  logic inc,
  input  logic clr,
  output logic atMax
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign atMax = (cnt == W'(MAX));

  // count refused cycles, hold at MAX, clear on issue
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !atMax) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: display memory arbiter, scanout over CPU.
// Define VGA_ARB_STARVE_GUARD_EN to bound CPU wait on solid ticks.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clkIn,
  input  logic              rstN,
  input  logic              pixelTick,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic [DATA_W-1:0] vgaData,
  output logic              vgaValid,
  output logic              vgaMiss,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  own_t own1;
  own_t own2;
  logic cpuBusy;
  logic cpuElig;
  logic cpuIssue;
  logic vgaIssue;
  logic forceCpu;
  logic cpuDone;

  if (CPU_MAX_WAIT < 1) begin : gWaitCheck
    $error("CPU_MAX_WAIT must be at least 1");
  end

  // the ack cycle still counts as busy: the
  // requester only drops cpuReq after seeing it
  assign cpuElig = cpuReq && !cpuBusy && !cpuAck;

`ifdef VGA_ARB_STARVE_GUARD_EN
  logic waitMax;

  assign forceCpu = cpuElig && waitMax;

  arb_wait_counter #(
    .MAX(CPU_MAX_WAIT)
  ) uWait (
    .clkIn(clkIn),
    .rstN (rstN),
    .inc  (cpuElig && !cpuIssue),
    .clr  (cpuIssue),
    .atMax(waitMax)
  );

  // report the tick lost to a forced CPU issue
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      vgaMiss <= 1'b0;
    end else begin
      vgaMiss <= pixelTick && forceCpu;
    end
  end
`else
  assign forceCpu = 1'b0;
  assign vgaMiss  = 1'b0;
`endif

  assign vgaIssue = pixelTick && !forceCpu;
  assign cpuIssue = cpuElig && (!pixelTick || forceCpu);
  assign cpuDone  = (own1 == CPU_WR) || (own2 == CPU_RD);

  // issue stage: one memory access per cycle
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      memAddr  <= '0;
      memWe    <= 1'b0;
      memWdata <= '0;
      own1     <= NONE;
    end else begin
      unique case (1'b1)
        vgaIssue: begin
          memAddr <= vgaAddr;
          memWe   <= 1'b0;
          own1    <= VGA;
        end
        cpuIssue: begin
          memAddr  <= cpuAddr;
          memWe    <= cpuWe;
          memWdata <= cpuWdata;
          own1     <= cpuWe ? CPU_WR : CPU_RD;
        end
        default: begin
          memWe <= 1'b0;
          own1  <= NONE;
        end
      endcase
    end
  end

  // capture stage: route read data, ack the CPU
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      own2     <= NONE;
      vgaData  <= '0;
      vgaValid <= 1'b0;
      cpuRdata <= '0;
      cpuAck   <= 1'b0;
      cpuBusy  <= 1'b0;
    end else begin
      own2     <= own1;
      vgaValid <= (own2 == VGA);
      cpuAck   <= cpuDone;
      if (own2 == VGA) begin
        vgaData <= memRdata;
      end
      if (own2 == CPU_RD) begin
        cpuRdata <= memRdata;
      end
      if (cpuIssue) begin
        cpuBusy <= 1'b1;
      end else if (cpuDone) begin
        cpuBusy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench with a memory
// model and a higher-level expected-data model.
module tb_vga_mem_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXW = 8;
`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clkIn = 1'b0;
  logic          rstN;
  logic          pixelTick;
  logic [AW-1:0] vgaAddr;
  logic [DW-1:0] vgaData;
  logic          vgaValid;
  logic          vgaMiss;
  logic          cpuReq;
  logic          cpuWe;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWdata;
  logic [DW-1:0] cpuRdata;
  logic          cpuAck;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;

  always #5 clkIn = ~clkIn;

  vga_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .CPU_MAX_WAIT(MAXW)
  ) dut (
    .clkIn    (clkIn),
    .rstN     (rstN),
    .pixelTick(pixelTick),
    .vgaAddr  (vgaAddr),
    .vgaData  (vgaData),
    .vgaValid (vgaValid),
    .vgaMiss  (vgaMiss),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .cpuAddr  (cpuAddr),
    .cpuWdata (cpuWdata),
    .cpuRdata (cpuRdata),
    .cpuAck   (cpuAck),
    .memAddr  (memAddr),
    .memWe    (memWe),
    .memWdata (memWdata),
    .memRdata (memRdata)
  );

  typedef struct {
    logic [7:0] data;
    bit         isRd;
    int         due;
  } exp_t;

  exp_t vgaQ[$];
  exp_t cpuQ[$];
  exp_t ve;
  exp_t ce;

  int checks  = 0;
  int passed  = 0;
  int cyc     = 0;
  int ackCnt  = 0;
  int missCnt = 0;

  logic [7:0] refMem [int];
  bit   [7:0] mem     [0:16383];
  bit         written [0:16383];

  function automatic logic [7:0] initVal(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], a[1:0]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] refRead(input logic [13:0] a);
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    return initVal(a);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  // synchronous single-port display memory, 1-cycle read
  always @(posedge clkIn) begin
    if (memWe) begin
      mem[memAddr]     <= memWdata;
      written[memAddr] <= 1'b1;
    end
    memRdata <= written[memAddr] ? mem[memAddr] : initVal(memAddr);
  end

  always @(posedge clkIn) cyc <= cyc + 1;

  // monitor: pop and compare on every DUT output event
  always @(negedge clkIn) begin
    if (rstN === 1'b1) begin
      if (vgaMiss) missCnt++;
      if (vgaValid) begin
        if (vgaQ.size() == 0) begin
          chk("vgaUnexpected", 1, 0);
        end else begin
          ve = vgaQ.pop_front();
          chk("vgaData", int'(vgaData), int'(ve.data));
          chk("vgaLatency", cyc, ve.due);
        end
      end
      if (cpuAck) begin
        ackCnt++;
        if (cpuQ.size() == 0) begin
          chk("cpuUnexpected", 1, 0);
        end else begin
          ce = cpuQ.pop_front();
          if (ce.isRd) chk("cpuRdata", int'(cpuRdata), int'(ce.data));
          if (ce.due != 0) chk("cpuAckCycle", cyc, ce.due);
        end
      end
    end
  end

  task automatic pushVga(input logic [13:0] a);
    exp_t e;
    e.data = refRead(a);
    e.isRd = 1'b1;
    e.due  = cyc + 3;
    vgaQ.push_back(e);
  endtask

  task automatic pulseTick(input logic [13:0] a);
    pixelTick = 1'b1;
    vgaAddr   = a;
    pushVga(a);
    @(posedge clkIn);
    #1;
    pixelTick = 1'b0;
  endtask

  task automatic cpuAccess(input bit we, input logic [13:0] a,
                           input logic [7:0] d, input int dueOff,
                           input int bound);
    exp_t e;
    bit   got;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = a;
    cpuWdata = d;
    e.data   = we ? 8'h00 : refRead(a);
    e.isRd   = !we;
    e.due    = (dueOff == 0) ? 0 : cyc + dueOff;
    cpuQ.push_back(e);
    if (we) refMem[int'(a)] = d;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clkIn);
      got = cpuAck;
    end
    @(posedge clkIn);
    #1;
    cpuReq = 1'b0;
    if (!got) begin
      chk("cpuTimeout", 0, 1);
      cpuQ.delete();
    end
  endtask

  task automatic chkOutsZero();
    chk("rstVgaData", int'(vgaData), 0);
    chk("rstVgaValid", int'(vgaValid), 0);
    chk("rstVgaMiss", int'(vgaMiss), 0);
    chk("rstCpuRdata", int'(cpuRdata), 0);
    chk("rstCpuAck", int'(cpuAck), 0);
    chk("rstMemAddr", int'(memAddr), 0);
    chk("rstMemWe", int'(memWe), 0);
    chk("rstMemWdata", int'(memWdata), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int  ack0;
    bit  vgaDone;
    logic [13:0] a;

    rstN      = 1'b1;
    pixelTick = 1'b0;
    vgaAddr   = '0;
    cpuReq    = 1'b0;
    cpuWe     = 1'b0;
    cpuAddr   = '0;
    cpuWdata  = '0;
    #1;
    rstN = 1'b0;
    #1;
    chkOutsZero();
    repeat (2) @(posedge clkIn);
    #3;
    rstN = 1'b1;
    @(posedge clkIn);
    #1;

    // preload 0x0123 then scan it out
    cpuAccess(1'b1, 14'h0123, 8'h5A, 2, 10);
    pulseTick(14'h0123);
    repeat (4) @(posedge clkIn);
    #1;

    // CPU write then read back
    cpuAccess(1'b1, 14'h0040, 8'hC3, 2, 10);
    cpuAccess(1'b0, 14'h0040, 8'h00, 3, 10);
    repeat (3) @(posedge clkIn);
    #1;

    // collision: VGA first, CPU one cycle later
    fork
      pulseTick(14'h0321);
      cpuAccess(1'b0, 14'h0010, 8'h00, 4, 10);
    join
    repeat (4) @(posedge clkIn);
    #1;

    // interleave: tick every 2nd cycle, continuous CPU traffic
    vgaDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          pulseTick(14'($urandom_range(0, 4095)));
          @(posedge clkIn);
          #1;
        end
        vgaDone = 1'b1;
      end
      begin
        while (!vgaDone) begin
          if ($urandom_range(0, 3) == 0) begin
            a = 14'h2000 | 14'($urandom_range(0, 255));
            cpuAccess(1'b1, a, 8'($urandom), 0, 10);
          end else begin
            if ($urandom_range(0, 1) == 0)
              a = 14'h2000 | 14'($urandom_range(0, 255));
            else
              a = 14'($urandom_range(0, 4095));
            cpuAccess(1'b0, a, 8'h00, 0, 10);
          end
        end
      end
    join
    repeat (5) @(posedge clkIn);
    #1;
    chk("missAfterInterleave", missCnt, 0);

    // solid ticks with a pending CPU write
    ack0 = ackCnt;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a         = 14'($urandom_range(0, 4095));
          vgaAddr   = a;
          pixelTick = 1'b1;
          if (!(GUARD && i == MAXW)) pushVga(a);
          @(posedge clkIn);
          #1;
        end
        pixelTick = 1'b0;
        chk("ackDuringTicks", ackCnt - ack0, GUARD ? 1 : 0);
      end
      cpuAccess(1'b1, 14'h2055, 8'hA7, 0, 60);
    join
    repeat (5) @(posedge clkIn);
    #1;
    chk("ackAfterTicks", ackCnt - ack0, 1);
    chk("missAfterTicks", missCnt, GUARD ? 1 : 0);

    // reset one cycle after a CPU read issues
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = 14'h2055;
    @(posedge clkIn);
    @(posedge clkIn);
    #2;
    rstN = 1'b0;
    #1;
    chkOutsZero();
    cpuReq = 1'b0;
    vgaQ.delete();
    cpuQ.delete();
    ack0 = ackCnt;
    repeat (2) @(posedge clkIn);
    #3;
    rstN = 1'b1;
    repeat (5) @(posedge clkIn);
    #1;
    chk("ackAfterReset", ackCnt - ack0, 0);
    cpuAccess(1'b0, 14'h2055, 8'h00, 3, 10);
    cpuAccess(1'b1, 14'h2056, 8'h3E, 2, 10);
    cpuAccess(1'b0, 14'h2056, 8'h00, 3, 10);

    for (int i = 0; i < 20 && (vgaQ.size() + cpuQ.size()) > 0; i++)
      @(posedge clkIn);
    #1;
    chk("vgaQEmpty", vgaQ.size(), 0);
    chk("cpuQEmpty", cpuQ.size(), 0);
    chk("missTotal", missCnt, GUARD ? 1 : 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
